addr_req_demux: RTL and testbench

ADDR_REQ_DEMUX -- requirements
Module: addr_req_demux

---
 rtl/addr_req_demux_pkg.sv | 19 +
 rtl/addr_decode.sv | 45 ++++
 rtl/addr_req_demux.sv | 154 +++++++++++++++
 tb/tb_addr_req_demux.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/addr_req_demux_pkg.sv
// Shared types for addr_req_demux: default rule layout, tracker state and error port placement.
package addr_req_demux_pkg;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } rule_t;

  typedef enum logic [1:0] {IDLE, ACTIVE, FULL} state_e;

  // Error responder sits at pseudo-port NoPorts + ERR_PORT_OFFSET.
  localparam int unsigned ERR_PORT_OFFSET = 0;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addr_decode.sv
// Address-map decoder: start inclusive, end exclusive (end 0 = top of space); the highest-numbered hit wins.
module addr_decode #(
  parameter int unsigned NoIndices = 2,
  parameter int unsigned NoRules   = 1,
  parameter int unsigned AddrWidth = 32,
  parameter type         rule_t    = addr_req_demux_pkg::rule_t,
  parameter bit          Napot     = 1'b0,
  parameter int unsigned IdxWidth  = addr_req_demux_pkg::idx_w(NoIndices)
) (
  input  logic [AddrWidth-1:0] addr_i,
  input  rule_t [NoRules-1:0]  addr_map_i,
  output logic [IdxWidth-1:0]  idx_o,
  output logic                 dec_valid_o,
  output logic                 dec_error_o,
  input  logic                 en_default_idx_i,
  input  logic [IdxWidth-1:0]  default_idx_i
);

  logic [NoRules-1:0] w_hit;
  logic               w_unused_map;

  for (genvar i = 0; i < NoRules; i++) begin : g_rule
    logic [AddrWidth-1:0] w_start, w_end;
    assign w_start  = AddrWidth'(addr_map_i[i].start_addr);
    assign w_end    = AddrWidth'(addr_map_i[i].end_addr);
    // In NAPOT mode end_addr carries the mask instead of a bound.
    assign w_hit[i] = Napot ? (((addr_i ^ w_start) & w_end) == '0)
                            : ((addr_i >= w_start) && ((addr_i < w_end) || (w_end == '0)));
  end

  always_comb begin
    idx_o       = en_default_idx_i ? default_idx_i : '0;
    dec_valid_o = 1'b0;
    for (int unsigned i = 0; i < NoRules; i++) begin
      if (w_hit[i]) begin
        dec_valid_o = 1'b1;
        idx_o       = IdxWidth'(addr_map_i[i].idx);
      end
    end
    dec_error_o = !(dec_valid_o || en_default_idx_i);
  end

  assign w_unused_map = ^addr_map_i;

endmodule

// File: rtl/addr_req_demux.sv
// One-to-NoPorts request demux with in-order response return via a single-target outstanding tracker.
// Define ADDR_REQ_DEMUX_ERR_RESP_EN to route unmatched addresses to an internal error responder.
module addr_req_demux
  import addr_req_demux_pkg::*;
#(
  parameter int unsigned NoPorts   = 2,
  parameter int unsigned NoRules   = 1,
  parameter int unsigned MaxTrans  = 4,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter type         rule_t    = addr_req_demux_pkg::rule_t,
  localparam int unsigned IdxW     = idx_w(NoPorts),
  localparam int unsigned CntW     = $clog2(MaxTrans + 1)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [AddrWidth-1:0]              req_addr_i,
  input  logic                              req_we_i,
  input  logic [DataWidth-1:0]              req_wdata_i,
  input  rule_t [NoRules-1:0]               addr_map_i,
  input  logic [IdxW-1:0]                   default_idx_i,
  output logic [NoPorts-1:0]                mst_req_valid_o,
  input  logic [NoPorts-1:0]                mst_req_ready_i,
  output logic [AddrWidth-1:0]              mst_req_addr_o,
  output logic                              mst_req_we_o,
  output logic [DataWidth-1:0]              mst_req_wdata_o,
  input  logic [NoPorts-1:0]                mst_rsp_valid_i,
  output logic [NoPorts-1:0]                mst_rsp_ready_o,
  input  logic [NoPorts-1:0][DataWidth-1:0] mst_rsp_rdata_i,
  input  logic [NoPorts-1:0]                mst_rsp_err_i,
  output logic                              rsp_valid_o,
  input  logic                              rsp_ready_i,
  output logic [DataWidth-1:0]              rsp_rdata_o,
  output logic                              rsp_err_o,
  output logic                              busy_o
);

`ifdef ADDR_REQ_DEMUX_ERR_RESP_EN
  localparam int unsigned SelW = $clog2(NoPorts + ERR_PORT_OFFSET + 1);
  localparam logic [SelW-1:0] ErrPort = SelW'(NoPorts + ERR_PORT_OFFSET);
`else
  localparam int unsigned SelW = IdxW;
`endif

  logic [IdxW-1:0] w_dec_idx, w_def_idx;
  logic            w_dec_valid, w_dec_error, w_en_def, w_unused;
  logic [SelW-1:0] w_tgt;
  logic            w_allow, w_rsp_act, w_req_hs, w_rsp_hs;
  logic [CntW-1:0] w_cnt_nxt;

  logic [SelW-1:0] r_sel;
  logic [CntW-1:0] r_cnt;
  state_e          r_state;

  addr_decode #(
    .NoIndices (NoPorts),
    .NoRules   (NoRules),
    .AddrWidth (AddrWidth),
    .rule_t    (rule_t),
    .Napot     (1'b0),
    .IdxWidth  (IdxW)
  ) i_dec (
    .addr_i           (req_addr_i),
    .addr_map_i       (addr_map_i),
    .idx_o            (w_dec_idx),
    .dec_valid_o      (w_dec_valid),
    .dec_error_o      (w_dec_error),
    .en_default_idx_i (w_en_def),
    .default_idx_i    (w_def_idx)
  );

`ifdef ADDR_REQ_DEMUX_ERR_RESP_EN
  assign w_en_def  = 1'b0;
  assign w_def_idx = '0;
  assign w_tgt     = w_dec_error ? ErrPort : SelW'(w_dec_idx);
  assign w_unused  = w_dec_valid ^ (^default_idx_i);
`else
  assign w_en_def  = 1'b1;
  assign w_def_idx = default_idx_i;
  assign w_tgt     = w_dec_idx;
  assign w_unused  = w_dec_valid ^ w_dec_error;
`endif

  assign mst_req_addr_o  = req_addr_i;
  assign mst_req_we_o    = req_we_i;
  assign mst_req_wdata_o = req_wdata_i;

  // New requests may only join in-flight ones headed to the same port, which keeps responses ordered.
  assign w_allow = rst_ni && ((r_state == IDLE) || ((r_state == ACTIVE) && (w_tgt == r_sel)));

  always_comb begin
    mst_req_valid_o = '0;
    req_ready_o     = 1'b0;
    for (int unsigned p = 0; p < NoPorts; p++) begin
      if (w_tgt == SelW'(p)) begin
        mst_req_valid_o[p] = w_allow && req_valid_i;
        req_ready_o        = w_allow && mst_req_ready_i[p];
      end
    end
`ifdef ADDR_REQ_DEMUX_ERR_RESP_EN
    if (w_tgt == ErrPort) req_ready_o = w_allow;
`endif
  end

  assign w_rsp_act = rst_ni && (r_cnt != '0);

  always_comb begin
    rsp_valid_o     = 1'b0;
    rsp_rdata_o     = '0;
    rsp_err_o       = 1'b0;
    mst_rsp_ready_o = '0;
    for (int unsigned p = 0; p < NoPorts; p++) begin
      if (w_rsp_act && (r_sel == SelW'(p))) begin
        rsp_valid_o        = mst_rsp_valid_i[p];
        rsp_rdata_o        = mst_rsp_rdata_i[p];
        rsp_err_o          = mst_rsp_err_i[p];
        mst_rsp_ready_o[p] = rsp_ready_i;
      end
    end
`ifdef ADDR_REQ_DEMUX_ERR_RESP_EN
    if (w_rsp_act && (r_sel == ErrPort)) begin
      rsp_valid_o = 1'b1;
      rsp_err_o   = 1'b1;
    end
`endif
  end

  assign w_req_hs = req_valid_i && req_ready_o;
  assign w_rsp_hs = rsp_valid_o && rsp_ready_i;
  assign busy_o   = rst_ni && (r_cnt != '0);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_req_hs && !w_rsp_hs)      w_cnt_nxt = r_cnt + 1'b1;
    else if (!w_req_hs && w_rsp_hs) w_cnt_nxt = r_cnt - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt   <= '0;
      r_sel   <= '0;
      r_state <= IDLE;
    end else begin
      if (w_req_hs) r_sel <= w_tgt;
      r_cnt <= w_cnt_nxt;
      if (w_cnt_nxt == '0)                  r_state <= IDLE;
      else if (w_cnt_nxt == CntW'(MaxTrans)) r_state <= FULL;
      else                                  r_state <= ACTIVE;
    end
  end

endmodule

// File: tb/tb_addr_req_demux.sv
// Directed bench for addr_req_demux: outstanding-target queue model checked every cycle, plus literal expectations.
module tb_addr_req_demux;
  import addr_req_demux_pkg::*;

  localparam int NP = 2, NR = 3, MT = 4, AW = 32, DW = 32;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                    req_valid, req_ready, req_we;
  logic [AW-1:0]           req_addr;
  logic [DW-1:0]           req_wdata;
  rule_t [NR-1:0]          amap;
  logic [0:0]              def_idx;
  logic [NP-1:0]           m_req_valid, m_req_ready;
  logic [AW-1:0]           m_addr;
  logic                    m_we;
  logic [DW-1:0]           m_wdata;
  logic [NP-1:0]           m_rsp_valid, m_rsp_ready, m_rsp_err;
  logic [NP-1:0][DW-1:0]   m_rsp_rdata;
  logic                    rsp_valid, rsp_ready, rsp_err, busy;
  logic [DW-1:0]           rsp_rdata;

  addr_req_demux #(
    .NoPorts(NP), .NoRules(NR), .MaxTrans(MT), .AddrWidth(AW), .DataWidth(DW), .rule_t(rule_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_wdata_i(req_wdata),
    .addr_map_i(amap), .default_idx_i(def_idx),
    .mst_req_valid_o(m_req_valid), .mst_req_ready_i(m_req_ready),
    .mst_req_addr_o(m_addr), .mst_req_we_o(m_we), .mst_req_wdata_o(m_wdata),
    .mst_rsp_valid_i(m_rsp_valid), .mst_rsp_ready_o(m_rsp_ready),
    .mst_rsp_rdata_i(m_rsp_rdata), .mst_rsp_err_i(m_rsp_err),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .busy_o(busy)
  );

  int n_vec = 0, n_err = 0;
  int q[$];

  logic          lit_en = 1'b0;
  logic [NP-1:0] lit_mv, lit_mr;
  logic          lit_rd, lit_bz, lit_rv;

  // Port that owns an address: last matching rule, else default / error port.
  function automatic int tgt_of(input logic [AW-1:0] a);
    int t;
`ifdef ADDR_REQ_DEMUX_ERR_RESP_EN
    t = NP;
`else
    t = int'(def_idx);
`endif
    for (int i = 0; i < NR; i++)
      if (a >= amap[i].start_addr && (a < amap[i].end_addr || amap[i].end_addr == 0))
        t = int'(amap[i].idx);
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : p_cmp
    int            t;
    bit            allow, e_rdy, e_rvld, e_rerr;
    logic [NP-1:0] e_mvld, e_mrdy;
    logic [DW-1:0] e_rdata;
    if (lit_en) begin
      chk("lit_mst_req_valid", 64'(m_req_valid), 64'(lit_mv));
      chk("lit_req_ready", 64'(req_ready), 64'(lit_rd));
      chk("lit_busy", 64'(busy), 64'(lit_bz));
      chk("lit_rsp_valid", 64'(rsp_valid), 64'(lit_rv));
      chk("lit_mst_rsp_ready", 64'(m_rsp_ready), 64'(lit_mr));
    end
    if (!rst_n) begin
      chk("rst_mst_req_valid", 64'(m_req_valid), 64'(0));
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_mst_rsp_ready", 64'(m_rsp_ready), 64'(0));
      q.delete();
    end else begin
      t      = tgt_of(req_addr);
      allow  = (q.size() == 0) || (q.size() < MT && q[0] == t);
      e_mvld = '0;
      e_rdy  = 1'b0;
      if (allow) begin
        if (t < NP) begin
          e_mvld[t] = req_valid;
          e_rdy     = m_req_ready[t];
        end else e_rdy = 1'b1;
      end
      e_mrdy = '0; e_rvld = 1'b0; e_rdata = '0; e_rerr = 1'b0;
      if (q.size() > 0) begin
        if (q[0] < NP) begin
          e_rvld        = m_rsp_valid[q[0]];
          e_mrdy[q[0]]  = rsp_ready;
          e_rdata       = m_rsp_rdata[q[0]];
          e_rerr        = m_rsp_err[q[0]];
        end else begin
          e_rvld = 1'b1;
          e_rerr = 1'b1;
        end
      end
      chk("mst_req_valid", 64'(m_req_valid), 64'(e_mvld));
      chk("req_ready", 64'(req_ready), 64'(e_rdy));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rvld));
      chk("mst_rsp_ready", 64'(m_rsp_ready), 64'(e_mrdy));
      chk("busy", 64'(busy), 64'(q.size() != 0));
      chk("mst_req_addr", 64'(m_addr), 64'(req_addr));
      chk("mst_req_we", 64'(m_we), 64'(req_we));
      chk("mst_req_wdata", 64'(m_wdata), 64'(req_wdata));
      if (e_rvld) begin
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
        chk("rsp_err", 64'(rsp_err), 64'(e_rerr));
      end
      if (e_rvld && rsp_ready) void'(q.pop_front());
      if (req_valid && e_rdy) q.push_back(t);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [AW-1:0] a, input logic [NP-1:0] mrdy,
                     input logic [NP-1:0] rv, input logic rr);
    req_valid   = v;
    req_addr    = a;
    m_req_ready = mrdy;
    m_rsp_valid = rv;
    rsp_ready   = rr;
  endtask

  task automatic lit(input logic [NP-1:0] mv, input logic rd, input logic bz,
                     input logic rv, input logic [NP-1:0] mr);
    lit_en = 1'b1;
    lit_mv = mv; lit_rd = rd; lit_bz = bz; lit_rv = rv; lit_mr = mr;
  endtask

  initial begin
    amap[0] = '{idx: 32'd0, start_addr: 32'h0000, end_addr: 32'h1000};
    amap[1] = '{idx: 32'd1, start_addr: 32'h1000, end_addr: 32'h2000};
    amap[2] = '{idx: 32'd0, start_addr: 32'h1800, end_addr: 32'h1900};
    def_idx        = 1'b1;
    req_we         = 1'b0;
    req_wdata      = 32'hCAFE_0001;
    m_rsp_rdata[0] = 32'h1111_0000;
    m_rsp_rdata[1] = 32'h2222_0001;
    m_rsp_err      = 2'b00;
    // Reset with live traffic on every input: everything must stay quiet.
    drv(1'b1, 32'h10, 2'b11, 2'b11, 1'b1);
    lit(2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    cyc(); cyc();

    rst_n = 1'b1;
    req_we = 1'b1;
    drv(1'b1, 32'h1004, 2'b10, 2'b00, 1'b0); lit(2'b10, 1'b1, 1'b0, 1'b0, 2'b00); cyc();
    req_we = 1'b0;
    drv(1'b0, 32'h1004, 2'b10, 2'b00, 1'b0); lit(2'b00, 1'b1, 1'b1, 1'b0, 2'b00); cyc();
    drv(1'b0, 32'h1004, 2'b10, 2'b10, 1'b1); lit(2'b00, 1'b1, 1'b1, 1'b1, 2'b10); cyc();

    // Fill to MaxTrans, stall, then free one slot.
    for (int k = 0; k < 4; k++) begin
      drv(1'b1, 32'h10, 2'b01, 2'b00, 1'b0); lit(2'b01, 1'b1, k != 0, 1'b0, 2'b00); cyc();
    end
    for (int k = 0; k < 2; k++) begin
      lit(2'b00, 1'b0, 1'b1, 1'b0, 2'b00); cyc();
    end
    drv(1'b1, 32'h10, 2'b01, 2'b01, 1'b1); lit(2'b00, 1'b0, 1'b1, 1'b1, 2'b01); cyc();
    drv(1'b1, 32'h10, 2'b01, 2'b00, 1'b1); lit(2'b01, 1'b1, 1'b1, 1'b0, 2'b01); cyc();
    for (int k = 0; k < 4; k++) begin
      drv(1'b0, 32'h10, 2'b01, 2'b01, 1'b1); lit(2'b00, k != 0, 1'b1, 1'b1, 2'b01); cyc();
    end
    lit(2'b00, 1'b1, 1'b0, 1'b0, 2'b00); cyc();

    // Different target stalls until port 0 drains.
    drv(1'b1, 32'h10,   2'b11, 2'b00, 1'b0); lit(2'b01, 1'b1, 1'b0, 1'b0, 2'b00); cyc();
    drv(1'b1, 32'h1000, 2'b11, 2'b00, 1'b0); lit(2'b00, 1'b0, 1'b1, 1'b0, 2'b00); cyc();
    drv(1'b1, 32'h1000, 2'b11, 2'b01, 1'b1); lit(2'b00, 1'b0, 1'b1, 1'b1, 2'b01); cyc();
    drv(1'b1, 32'h1000, 2'b11, 2'b00, 1'b1); lit(2'b10, 1'b1, 1'b0, 1'b0, 2'b00); cyc();
    drv(1'b0, 32'h1000, 2'b11, 2'b10, 1'b1); lit(2'b00, 1'b1, 1'b1, 1'b1, 2'b10); cyc();

    // Simultaneous request and response leaves count at 2.
    drv(1'b1, 32'h10, 2'b11, 2'b00, 1'b0); lit(2'b01, 1'b1, 1'b0, 1'b0, 2'b00); cyc();
    lit(2'b01, 1'b1, 1'b1, 1'b0, 2'b00); cyc();
    drv(1'b1, 32'h10, 2'b11, 2'b01, 1'b1); lit(2'b01, 1'b1, 1'b1, 1'b1, 2'b01); cyc();
    for (int k = 0; k < 2; k++) begin
      drv(1'b0, 32'h10, 2'b11, 2'b01, 1'b1); lit(2'b00, 1'b1, 1'b1, 1'b1, 2'b01); cyc();
    end
    drv(1'b0, 32'h10, 2'b11, 2'b00, 1'b0); lit(2'b00, 1'b1, 1'b0, 1'b0, 2'b00); cyc();

    // Overlapping rule: highest-numbered match sends 0x1850 to port 0.
    drv(1'b1, 32'h1850, 2'b11, 2'b00, 1'b0); lit(2'b01, 1'b1, 1'b0, 1'b0, 2'b00); cyc();
    drv(1'b0, 32'h1850, 2'b11, 2'b01, 1'b1); lit(2'b00, 1'b1, 1'b1, 1'b1, 2'b01); cyc();

    // Unmatched address.
    m_rsp_err = 2'b10;
`ifdef ADDR_REQ_DEMUX_ERR_RESP_EN
    drv(1'b1, 32'h8000, 2'b10, 2'b00, 1'b0); lit(2'b00, 1'b1, 1'b0, 1'b0, 2'b00); cyc();
    drv(1'b0, 32'h8000, 2'b10, 2'b00, 1'b1); lit(2'b00, 1'b1, 1'b1, 1'b1, 2'b00); cyc();
    drv(1'b0, 32'h8000, 2'b10, 2'b10, 1'b1); lit(2'b00, 1'b1, 1'b0, 1'b0, 2'b00); cyc();
`else
    drv(1'b1, 32'h8000, 2'b10, 2'b00, 1'b0); lit(2'b10, 1'b1, 1'b0, 1'b0, 2'b00); cyc();
    drv(1'b0, 32'h8000, 2'b10, 2'b00, 1'b1); lit(2'b00, 1'b1, 1'b1, 1'b0, 2'b10); cyc();
    drv(1'b0, 32'h8000, 2'b10, 2'b10, 1'b1); lit(2'b00, 1'b1, 1'b1, 1'b1, 2'b10); cyc();
`endif
    m_rsp_err = 2'b00;

    // Reset with three in flight; late response must be held off.
    for (int k = 0; k < 3; k++) begin
      drv(1'b1, 32'h10, 2'b01, 2'b00, 1'b0); lit(2'b01, 1'b1, k != 0, 1'b0, 2'b00); cyc();
    end
    rst_n = 1'b0;
    drv(1'b0, 32'h10, 2'b01, 2'b01, 1'b1); lit(2'b00, 1'b0, 1'b0, 1'b0, 2'b00); cyc();
    rst_n = 1'b1;
    lit(2'b00, 1'b1, 1'b0, 1'b0, 2'b00); cyc(); cyc();

    lit_en = 1'b0;
    drv(1'b0, 32'h10, 2'b00, 2'b00, 1'b0);
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
